// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared states, owner encoding and latched request record for the memory bus arbiter.
package mem_bus_arbiter_pkg;
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;
  localparam logic [2:0] FETCH_SIZE = 3'd3;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
  typedef enum logic [1:0] {NONE, OWN_I, OWN_D} arb_owner_t;
  typedef struct packed {
    logic [MAX_ADDR_W-1:0]   addr;
    logic [2:0]              size;
    logic [MAX_DATA_W/8-1:0] strobe;
    logic [MAX_DATA_W-1:0]   wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; MEM_ARB_RR_EN selects round-robin, otherwise D over I.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic       last_owner,
  output arb_owner_t winner
);
`ifdef MEM_ARB_RR_EN
  // last_owner: 1 = D was granted last, 0 = I
  assign winner = (i_valid && d_valid) ? (last_owner ? OWN_I : OWN_D) :
                  d_valid ? OWN_D : i_valid ? OWN_I : NONE;
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign winner = d_valid ? OWN_D : i_valid ? OWN_I : NONE;
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-outstanding memory bus between fetch (I) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin on collisions; default is fixed D-over-I priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_data,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ready,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_rdata
);
  arb_state_t state, state_n;
  arb_owner_t owner, owner_n, winner;
  mem_req_t   req_q, req_n;
  logic       last_owner, grant, addr_ok, data_ok;
  mem_arb_pick u_pick (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .last_owner (last_owner),
    .winner     (winner)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= NONE;
      req_q <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      if (grant) req_q <= req_n;
    end
  end
`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) last_owner <= 1'b0;
    else if (grant) last_owner <= (winner == OWN_D);
  end
`else
  assign last_owner = 1'b0;
`endif
  always_comb begin
    state_n = state;
    owner_n = owner;
    grant = 1'b0;
    req_n.addr = (winner == OWN_D) ? MAX_ADDR_W'(d_addr) : MAX_ADDR_W'(i_addr);
    req_n.size = (winner == OWN_D) ? d_size : FETCH_SIZE;
    req_n.strobe = (winner == OWN_D) ? (MAX_DATA_W/8)'(d_strobe) : '0;
    req_n.wdata = (winner == OWN_D) ? MAX_DATA_W'(d_wdata) : '0;
    case (state)
      IDLE: if (winner != NONE) begin
        grant = 1'b1;
        state_n = REQ;
        owner_n = winner;
      end
      REQ: if (m_ready) state_n = WAIT;
      WAIT: if (m_resp_valid) begin
        state_n = IDLE;
        owner_n = NONE;
      end
      default: state_n = IDLE;
    endcase
  end
  // a response arriving together with acceptance in REQ is not taken
  assign addr_ok   = (state == REQ) && m_ready;
  assign data_ok   = (state == WAIT) && m_resp_valid;
  assign i_addr_ok = addr_ok && (owner == OWN_I);
  assign d_addr_ok = addr_ok && (owner == OWN_D);
  assign i_data_ok = data_ok && (owner == OWN_I);
  assign d_data_ok = data_ok && (owner == OWN_D);
  assign i_data    = i_data_ok ? m_rdata : '0;
  assign d_rdata   = d_data_ok ? m_rdata : '0;
  assign m_valid   = (state == REQ);
  assign m_addr    = req_q.addr[ADDR_W-1:0];
  assign m_size    = req_q.size;
  assign m_strobe  = req_q.strobe[DATA_W/8-1:0];
  assign m_wdata   = req_q.wdata[DATA_W-1:0];
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between instruction fetch (I) and the load/store stage (D).
- Sits between the fetch/memory pipeline stages and the memory interface.
- Latches one winner per transaction, drives the shared request until it is accepted, then routes the single-beat response back to its owner.
- Only one transaction is outstanding at a time.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  fetch request.
- i_addr  in  ADDR_W  fetch address.
- i_addr_ok  out  1  fetch request accepted by memory.
- i_data_ok  out  1  fetch response valid.
- i_data  out  DATA_W  fetch read data.
- d_valid  in  1  data request.
- d_addr  in  ADDR_W  data address.
- d_size  in  3  log2 of byte count.
- d_strobe  in  DATA_W/8  write byte enables; 0 means read.
- d_wdata  in  DATA_W  store data.
- d_addr_ok  out  1  data request accepted.
- d_data_ok  out  1  data response valid.
- d_rdata  out  DATA_W  load data.
- m_valid  out  1  shared request.
- m_addr  out  ADDR_W
- m_size  out  3
- m_strobe  out  DATA_W/8
- m_wdata  out  DATA_W
- m_ready  in  1  memory accepts request.
- m_resp_valid  in  1  memory response, single beat.
- m_rdata  in  DATA_W

Behaviour:
- Reset: clk and reset are fixed as above. All outputs are 0, state is IDLE, owner is NONE, latched fields are 0.
- States:
  - IDLE: if i_valid or d_valid, pick a winner, latch its fields into registers, set owner, go to REQ. Otherwise stay.
  - REQ: m_valid=1 and m_* come from registers. When m_ready=1, pulse the owner's addr_ok combinationally in the same cycle, then go to WAIT.
  - WAIT: m_valid=0. When m_resp_valid=1, pulse the owner's data_ok in the same cycle with m_rdata passed through combinationally, then go to IDLE with owner NONE.
- Fetch latch: size=3 (8 bytes), strobe=0, wdata=0.
- Latency:
  - Request valid in cycle 0 gives m_valid in cycle 1.
  - Best case addr_ok is in cycle 1.
  - The next grant happens no earlier than the cycle after data_ok, so there is one IDLE bubble per transaction.
- Selection (default): fixed priority, D over I. This avoids deadlock when a load/store stalls the pipeline.
- Response routing:
  - i_data and d_rdata drive m_rdata only when their data_ok is high; otherwise 0.
  - addr_ok and data_ok go only to the latched owner, never to both.
- Boundary conditions:
  - m_ready and m_resp_valid in the same REQ cycle: take addr_ok only, go to WAIT. The response is not accepted in REQ; memory must present it again in WAIT.
  - m_resp_valid in IDLE or REQ: ignored.
  - Requester contract: a requester holds valid and fields stable until addr_ok. If it drops valid after grant, the transaction still completes and data_ok is still pulsed.
  - A requester whose valid is still high in the IDLE cycle after its data_ok is a new request.
  - Reset mid-transaction: IDLE next cycle, outputs 0, any in-flight response is dropped. The memory side is reset by the same signal.
- The m_* outputs are registered (state/field registers). addr_ok, data_ok and read data are combinational from m_ready, m_resp_valid and m_rdata.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin. A 1-bit last_owner register, reset to I. When both request in IDLE, grant the one that is not last_owner. last_owner updates at grant. A single requester is always granted.
- Undefined: fixed D-over-I priority; no last_owner register.

Decomposition:
- Shared package pipes:
  - arb_state_t enum {IDLE, REQ, WAIT}.
  - arb_owner_t enum {NONE, OWN_I, OWN_D}.
  - mem_req_t struct {addr, size, strobe, wdata}.
  - Constant FETCH_SIZE=3'd3.
- Sub-module mem_arb_pick: combinational winner select. Inputs i_valid, d_valid and last_owner; output arb_owner_t. It contains the MEM_ARB_RR_EN conditional.

Test Plan:
- Fetch alone:
  - Stimulus: i_valid, i_addr=0x8000_0000; m_ready in cycle 1; m_resp_valid with rdata=0x13 in cycle 3.
  - Response: m_valid in cycle 1 with strobe=0, size=3; i_addr_ok in cycle 1; i_data_ok with i_data=0x13 in cycle 3; state IDLE in cycle 4.
- Collision, fixed priority:
  - Stimulus: i_valid and d_valid (store, strobe=0xFF, wdata=0xDEAD) in the same cycle.
  - Response: D is served first with m_strobe=0xFF; I gets m_valid only after d_data_ok plus one idle cycle.
- Collision with MEM_ARB_RR_EN:
  - Stimulus: two back-to-back simultaneous request pairs.
  - Response: grant order is D then I.
- Backpressure:
  - Stimulus: m_ready held 0 for 5 cycles.
  - Response: m_valid and m_addr stay stable; no addr_ok until m_ready=1.
- Spurious/simultaneous handshake:
  - Stimulus: m_resp_valid in IDLE, then m_ready and m_resp_valid together in REQ.
  - Response: no data_ok in either cycle; data_ok only on the later WAIT response.
- Reset in WAIT:
  - Stimulus: assert reset during WAIT.
  - Response: all outputs 0 the next cycle; a later m_resp_valid produces no data_ok; a new i_valid is granted normally.
